// File: rtl/gol_ctrl.sv
// Sequencing controller for an 8x8 Game of Life datapath: owns the grid register,
// paces generations in RUN, supports load/step/pause, and halts on still life or a generation cap.
module gol_ctrl #(
  parameter logic [63:0] DEFAULT_SEED = 64'h4020_E000_0000_0000,
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned GEN_W        = 16,
  parameter int unsigned MAX_GEN      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      seed,
  input  logic             load,
  input  logic             run,
  input  logic             step,
  input  logic [63:0]      next_grid,
  output logic [63:0]      cur_grid,
  output logic [GEN_W-1:0] gen_count,
  output logic             gen_tick,
  output logic [1:0]       state,
  output logic             stable,
  output logic             empty
);

  localparam int unsigned      DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [GEN_W-1:0] GEN_CAP  = GEN_W'(MAX_GEN);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StPause = 2'b01,
    StRun   = 2'b10,
    StHalt  = 2'b11
  } state_e;

  state_e           r_state, w_state_d;
  logic [63:0]      r_grid, w_grid_d;
  logic [GEN_W-1:0] r_cnt, w_cnt_d, w_cnt_inc;
  logic [DIV_W-1:0] r_div, w_div_d;
  logic             r_tick, w_tick_d;
  logic             r_stable, w_stable_d;
  logic             w_upd;
  logic             w_same;

  assign w_same    = (next_grid == r_grid);
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_d  = r_state;
    w_grid_d   = r_grid;
    w_cnt_d    = r_cnt;
    w_div_d    = r_div;
    w_tick_d   = 1'b0;
    w_stable_d = r_stable;
    w_upd      = 1'b0;

    if (load) begin
      w_grid_d   = seed;
      w_cnt_d    = '0;
      w_stable_d = 1'b0;
      w_div_d    = '0;
      w_state_d  = StPause;
    end else begin
      case (r_state)
        StIdle, StPause: begin
          if (run) begin
            w_state_d = StRun;
            w_div_d   = '0;
          end else if (step) begin
            // A manual step leaves IDLE: the user is now driving generations by hand.
            w_state_d = StPause;
            w_upd     = 1'b1;
          end
        end
        StRun: begin
          if (!run) begin
            w_state_d = StPause;
            w_div_d   = '0;
          end else if (r_div == DIV_LAST) begin
            w_div_d = '0;
            w_upd   = 1'b1;
          end else begin
            w_div_d = r_div + 1'b1;
          end
        end
        default: ;
      endcase

      if (w_upd) begin
        if (w_same) begin
          w_stable_d = 1'b1;
          w_state_d  = StHalt;
        end else begin
          w_grid_d = next_grid;
          w_cnt_d  = w_cnt_inc;
          w_tick_d = 1'b1;
          if ((MAX_GEN != 0) && (w_cnt_inc == GEN_CAP)) begin
            w_state_d = StHalt;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_grid   <= DEFAULT_SEED;
      r_cnt    <= '0;
      r_div    <= '0;
      r_tick   <= 1'b0;
      r_stable <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_grid   <= w_grid_d;
      r_cnt    <= w_cnt_d;
      r_div    <= w_div_d;
      r_tick   <= w_tick_d;
      r_stable <= w_stable_d;
    end
  end

  assign cur_grid  = r_grid;
  assign gen_count = r_cnt;
  assign gen_tick  = r_tick;
  assign state     = r_state;
  assign stable    = r_stable;
  assign empty     = (r_grid == 64'd0);

endmodule

// File: tb/tb_gol_ctrl.sv
// Scoreboard bench for gol_ctrl: two instances (unlimited and MAX_GEN=2), each fed by a
// behavioural Game of Life datapath; expectations are queued by stimulus and checked by a monitor.
module tb_gol_ctrl;

  localparam logic [63:0] GLIDER  = 64'h4020_E000_0000_0000;
  localparam logic [63:0] G1      = 64'h00A0_6040_0000_0000;
  localparam logic [63:0] G2      = 64'h0020_A060_0000_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
  localparam logic [63:0] CELL    = 64'h0000_0008_0000_0000;
  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [1:0]  IDLE = 2'b00, PAUSE = 2'b01, RUN = 2'b10, HALT = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] seed0 = '0, seed1 = '0;
  logic        load0 = 1'b0, run0 = 1'b0, step0 = 1'b0;
  logic        load1 = 1'b0, run1 = 1'b0, step1 = 1'b0;
  logic [63:0] ng0, ng1, cur0, cur1;
  logic [15:0] cnt0, cnt1;
  logic        tick0, tick1, stb0, stb1, emp0, emp1;
  logic [1:0]  st0, st1;

  always #5 clk = ~clk;

  // Reference datapath: dead cells beyond the 8x8 edge, bit 63 = row 0 col 0.
  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] n;
    int          nb;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        nb = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              if (g[63 - ((r + dr) * 8 + (c + dc))]) nb++;
          end
        end
        if (nb == 3 || (nb == 2 && g[63 - (r * 8 + c)])) n[63 - (r * 8 + c)] = 1'b1;
      end
    end
    return n;
  endfunction

  assign ng0 = life(cur0);
  assign ng1 = life(cur1);

  gol_ctrl #(.TICK_DIV(4), .GEN_W(16), .MAX_GEN(0)) dut (
    .clk(clk), .reset(reset), .seed(seed0), .load(load0), .run(run0), .step(step0),
    .next_grid(ng0), .cur_grid(cur0), .gen_count(cnt0), .gen_tick(tick0), .state(st0),
    .stable(stb0), .empty(emp0)
  );

  gol_ctrl #(.TICK_DIV(4), .GEN_W(16), .MAX_GEN(2)) dut_cap (
    .clk(clk), .reset(reset), .seed(seed1), .load(load1), .run(run1), .step(step1),
    .next_grid(ng1), .cur_grid(cur1), .gen_count(cnt1), .gen_tick(tick1), .state(st1),
    .stable(stb1), .empty(emp1)
  );

  typedef struct packed {
    logic        sel;
    logic [1:0]  st;
    logic [63:0] grid;
    logic [15:0] cnt;
    logic        stb;
    logic        emp;
  } exp_t;

  typedef struct packed {
    logic [63:0] grid;
    logic [15:0] cnt;
  } tick_t;

  exp_t  exp_q[$];
  string nm_q[$];
  tick_t tq0[$], tq1[$];
  int    n_chk = 0;
  int    n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) $display("FAIL %s: got %h, expected %h", nm, act, req);
    else n_pass++;
  endtask

  task automatic expect_st(input string nm, input logic sel, input logic [1:0] st,
                           input logic [63:0] g, input logic [15:0] c, input logic s);
    exp_t e;
    e.sel  = sel;
    e.st   = st;
    e.grid = g;
    e.cnt  = c;
    e.stb  = s;
    e.emp  = (g == 64'd0);
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic push_tick(input logic sel, input logic [63:0] g, input logic [15:0] c);
    tick_t t;
    t.grid = g;
    t.cnt  = c;
    if (sel) tq1.push_back(t);
    else tq0.push_back(t);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: state expectations drain every falling edge; tick records pop on each gen_tick.
  exp_t  m_e;
  string m_n;
  tick_t m_t;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      m_n = nm_q.pop_front();
      check({m_n, ".state"},  64'(m_e.sel ? st1 : st0),    64'(m_e.st));
      check({m_n, ".grid"},   m_e.sel ? cur1 : cur0,       m_e.grid);
      check({m_n, ".count"},  64'(m_e.sel ? cnt1 : cnt0),  64'(m_e.cnt));
      check({m_n, ".stable"}, 64'(m_e.sel ? stb1 : stb0),  64'(m_e.stb));
      check({m_n, ".empty"},  64'(m_e.sel ? emp1 : emp0),  64'(m_e.emp));
    end
    if (tick0) begin
      if (tq0.size() == 0) check("tick0_spurious", 64'(tick0), 64'd0);
      else begin
        m_t = tq0.pop_front();
        check("tick0.grid", cur0, m_t.grid);
        check("tick0.count", 64'(cnt0), 64'(m_t.cnt));
      end
    end
    if (tick1) begin
      if (tq1.size() == 0) check("tick1_spurious", 64'(tick1), 64'd0);
      else begin
        m_t = tq1.pop_front();
        check("tick1.grid", cur1, m_t.grid);
        check("tick1.count", 64'(cnt1), 64'(m_t.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cyc(2);
    expect_st("reset", 1'b0, IDLE, GLIDER, 16'd0, 1'b0);
    expect_st("reset_cap", 1'b1, IDLE, GLIDER, 16'd0, 1'b0);
    reset = 1'b0;
    cyc(1);

    // Step from reset: glider advances once.
    push_tick(1'b0, G1, 16'd1);
    step0 = 1'b1;
    cyc(1);
    step0 = 1'b0;
    expect_st("step_glider", 1'b0, PAUSE, G1, 16'd1, 1'b0);
    cyc(1);

    // Block is a still life: halts, nothing advances, HALT ignores run/step.
    seed0 = BLOCK;
    load0 = 1'b1;
    cyc(1);
    load0 = 1'b0;
    expect_st("load_block", 1'b0, PAUSE, BLOCK, 16'd0, 1'b0);
    step0 = 1'b1;
    cyc(1);
    step0 = 1'b0;
    expect_st("block_step", 1'b0, HALT, BLOCK, 16'd0, 1'b1);
    step0 = 1'b1;
    run0 = 1'b1;
    cyc(2);
    step0 = 1'b0;
    run0 = 1'b0;
    expect_st("halt_ignores", 1'b0, HALT, BLOCK, 16'd0, 1'b1);

    // Single cell dies at the first tick, then the empty grid halts at the second.
    seed0 = CELL;
    load0 = 1'b1;
    cyc(1);
    load0 = 1'b0;
    expect_st("load_cell", 1'b0, PAUSE, CELL, 16'd0, 1'b0);
    push_tick(1'b0, 64'd0, 16'd1);
    run0 = 1'b1;
    cyc(1);
    expect_st("cell_run_enter", 1'b0, RUN, CELL, 16'd0, 1'b0);
    cyc(3);
    expect_st("cell_pre_tick", 1'b0, RUN, CELL, 16'd0, 1'b0);
    cyc(1);
    expect_st("cell_gen1", 1'b0, RUN, 64'd0, 16'd1, 1'b0);
    cyc(4);
    expect_st("cell_halt", 1'b0, HALT, 64'd0, 16'd1, 1'b1);
    run0 = 1'b0;
    cyc(1);
    expect_st("cell_halt_hold", 1'b0, HALT, 64'd0, 16'd1, 1'b1);

    // Blinker: load works from HALT, three ticks in 12 RUN cycles, then pause and step.
    seed0 = BLINK_H;
    load0 = 1'b1;
    cyc(1);
    load0 = 1'b0;
    expect_st("load_blinker", 1'b0, PAUSE, BLINK_H, 16'd0, 1'b0);
    run0 = 1'b1;
    cyc(1);
    for (int k = 1; k <= 3; k++) begin
      push_tick(1'b0, (k % 2 == 1) ? BLINK_V : BLINK_H, 16'(k));
      cyc(4);
      expect_st("blink_run", 1'b0, RUN, (k % 2 == 1) ? BLINK_V : BLINK_H, 16'(k), 1'b0);
    end
    run0 = 1'b0;
    cyc(1);
    expect_st("blink_pause", 1'b0, PAUSE, BLINK_V, 16'd3, 1'b0);
    push_tick(1'b0, BLINK_H, 16'd4);
    step0 = 1'b1;
    cyc(1);
    step0 = 1'b0;
    expect_st("blink_step4", 1'b0, PAUSE, BLINK_H, 16'd4, 1'b0);
    push_tick(1'b0, BLINK_V, 16'd5);
    step0 = 1'b1;
    cyc(1);
    step0 = 1'b0;
    expect_st("blink_step5", 1'b0, PAUSE, BLINK_V, 16'd5, 1'b0);

    // Dropping run on the very edge where the tick would fire: pause with no update.
    run0 = 1'b1;
    cyc(4);
    expect_st("coincide_run", 1'b0, RUN, BLINK_V, 16'd5, 1'b0);
    run0 = 1'b0;
    cyc(1);
    expect_st("coincide_pause", 1'b0, PAUSE, BLINK_V, 16'd5, 1'b0);

    // MAX_GEN=2 instance: halts after two updates without stable; load recovers.
    seed1 = GLIDER;
    load1 = 1'b1;
    cyc(1);
    load1 = 1'b0;
    expect_st("cap_load", 1'b1, PAUSE, GLIDER, 16'd0, 1'b0);
    push_tick(1'b1, G1, 16'd1);
    push_tick(1'b1, G2, 16'd2);
    run1 = 1'b1;
    cyc(5);
    expect_st("cap_gen1", 1'b1, RUN, G1, 16'd1, 1'b0);
    cyc(4);
    expect_st("cap_halt", 1'b1, HALT, G2, 16'd2, 1'b0);
    step1 = 1'b1;
    cyc(3);
    step1 = 1'b0;
    expect_st("cap_halt_hold", 1'b1, HALT, G2, 16'd2, 1'b0);
    run1 = 1'b0;
    load1 = 1'b1;
    cyc(1);
    load1 = 1'b0;
    expect_st("cap_reload", 1'b1, PAUSE, GLIDER, 16'd0, 1'b0);

    // Asynchronous reset between ticks, then load+step together loads only.
    run0 = 1'b1;
    cyc(3);
    reset = 1'b1;
    #1;
    expect_st("reset_mid_run", 1'b0, IDLE, GLIDER, 16'd0, 1'b0);
    run0 = 1'b0;
    cyc(1);
    reset = 1'b0;
    seed0 = BLINK_H;
    load0 = 1'b1;
    step0 = 1'b1;
    cyc(1);
    load0 = 1'b0;
    step0 = 1'b0;
    expect_st("load_beats_step", 1'b0, PAUSE, BLINK_H, 16'd0, 1'b0);
    cyc(3);

    check("tick0_pending", 64'(tq0.size()), 64'd0);
    check("tick1_pending", 64'(tq1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
